// File: rtl/onewire_uart_seq.sv
// rtl/onewire_uart_seq.sv - UART command sequencer driving a 1-Wire byte master
module onewire_uart_seq #(
    parameter int         FIFO_DEPTH     = 16,
    parameter int         POLL_CYCLES    = 100000,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_read,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_busy,
    output logic [1:0] ow_cmd,
    output logic [7:0] ow_wdat,
    output logic       ow_vld,
    input  logic       ow_rdy,
    input  logic       ow_done,
    input  logic [7:0] ow_rdat,
    input  logic       ow_presence,
    output logic       busy,
    output logic       poll_en
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_RST  = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;
    localparam logic [1:0] OP_MODE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_RST_REQ, S_WR_FETCH,
        S_WR_REQ, S_RD_REQ, S_WAIT, S_WR_DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cmd_byte;
    logic [1:0]    cur_op;
    logic [6:0]    cnt;
    logic [5:0]    rd_len;
    logic          rd_seen;
    logic          poll_pend;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] tmo_cnt;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic          push, push_ok, pop, fifo_full;
    logic [7:0]    push_data;
    logic          rx_take, hs, tmo_hit, poll_wrap, last_byte;

    assign fifo_full = (fifo_cnt == FIFO_FULL);
    assign push_ok   = push & ~fifo_full;
    assign pop       = (fifo_cnt != '0) & ~tx_busy & ~tx_write;
    // rx_valid is ignored while rx_read is high so the popped byte is never seen twice
    assign rx_take   = rx_valid & ~rx_read;
    assign hs        = ow_vld & ow_rdy;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign poll_wrap = (poll_cnt == POLL_LAST);
    assign last_byte = (cnt == 7'd1);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = ERR_BYTE;
        ow_vld    = 1'b0;
        ow_cmd    = 2'd0;
        case (state)
            S_IDLE: begin
                if (poll_pend)    state_nxt = S_RD_REQ;
                else if (rx_take) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (cmd_byte[7:6])
                    OP_RST:  state_nxt = S_RST_REQ;
                    OP_WR:   state_nxt = S_WR_FETCH;
                    OP_RD:   state_nxt = S_RD_REQ;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_RST_REQ: begin
                ow_vld = 1'b1;
                ow_cmd = 2'd0;
                if (ow_rdy) state_nxt = S_WAIT;
            end
            S_WR_FETCH: begin
                if (rx_take) state_nxt = S_WR_REQ;
            end
            S_WR_REQ: begin
                ow_vld = 1'b1;
                ow_cmd = 2'd1;
                if (ow_rdy) state_nxt = S_WAIT;
            end
            S_RD_REQ: begin
                // each read needs a guaranteed FIFO slot for its result
                if (!fifo_full) begin
                    ow_vld = 1'b1;
                    ow_cmd = 2'd2;
                    if (ow_rdy) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ow_done) begin
                    case (cur_op)
                        OP_RST: begin
                            push      = 1'b1;
                            push_data = {7'd0, ow_presence};
                            state_nxt = S_IDLE;
                        end
                        OP_WR: state_nxt = last_byte ? S_IDLE : S_WR_FETCH;
                        OP_RD: begin
                            push      = 1'b1;
                            push_data = ow_rdat;
                            state_nxt = last_byte ? S_IDLE : S_RD_REQ;
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end else if (tmo_hit) begin
                    push      = 1'b1;
                    push_data = ERR_BYTE;
                    state_nxt = (cur_op == OP_WR && !last_byte) ? S_WR_DRAIN : S_IDLE;
                end
            end
            S_WR_DRAIN: begin
                if (rx_take && last_byte) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_byte  <= '0;
            cur_op    <= OP_RST;
            cnt       <= '0;
            rd_len    <= '0;
            rd_seen   <= 1'b0;
            poll_pend <= 1'b0;
            poll_cnt  <= '0;
            tmo_cnt   <= '0;
            poll_en   <= 1'b0;
            rx_read   <= 1'b0;
            ow_wdat   <= '0;
        end else begin
            rx_read  <= 1'b0;
            poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);

            case (state)
                S_IDLE: begin
                    if (poll_pend) begin
                        cur_op <= OP_RD;
                        cnt    <= {1'b0, rd_len} + 7'd1;
                    end else if (rx_take) begin
                        cmd_byte <= rx_data;
                        rx_read  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    cur_op <= cmd_byte[7:6];
                    cnt    <= {1'b0, cmd_byte[5:0]} + 7'd1;
                    if (cmd_byte[7:6] == OP_RD) begin
                        rd_len  <= cmd_byte[5:0];
                        rd_seen <= 1'b1;
                    end
                    if (cmd_byte[7:6] == OP_MODE) poll_en <= cmd_byte[0];
                end
                S_WR_FETCH: begin
                    if (rx_take) begin
                        ow_wdat <= rx_data;
                        rx_read <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ow_done || tmo_hit) cnt <= cnt - 7'd1;
                end
                S_WR_DRAIN: begin
                    if (rx_take) begin
                        rx_read <= 1'b1;
                        cnt     <= cnt - 7'd1;
                    end
                end
                default: ;
            endcase

            if (hs)
                tmo_cnt <= '0;
            else if (state == S_WAIT && !ow_done && !tmo_hit)
                tmo_cnt <= tmo_cnt + TW'(1);

            // launching consumes the request; further wraps while busy collapse into one
            if (state == S_IDLE && poll_pend)
                poll_pend <= 1'b0;
            else if (state == S_DECODE && cmd_byte[7:6] == OP_MODE && !cmd_byte[0])
                poll_pend <= 1'b0;
            else if (poll_wrap && poll_en && rd_seen)
                poll_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_data  <= '0;
            tx_write <= 1'b0;
        end else begin
            tx_write <= pop;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                tx_data <= fifo_mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_uart_seq.sv
// tb/tb_onewire_uart_seq.sv - self-checking bench for onewire_uart_seq
module tb_onewire_uart_seq;

    localparam int FD = 4;
    localparam int PC = 1000;
    localparam int TC = 300;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_read;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_busy;
    logic [1:0] ow_cmd;
    logic [7:0] ow_wdat;
    logic       ow_vld;
    logic       ow_rdy;
    logic       ow_done;
    logic [7:0] ow_rdat;
    logic       ow_presence;
    logic       busy;
    logic       poll_en;

    onewire_uart_seq #(
        .FIFO_DEPTH(FD), .POLL_CYCLES(PC), .TIMEOUT_CYCLES(TC), .ERR_BYTE(8'hEE)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
        .tx_data(tx_data), .tx_write(tx_write), .tx_busy(tx_busy),
        .ow_cmd(ow_cmd), .ow_wdat(ow_wdat), .ow_vld(ow_vld), .ow_rdy(ow_rdy),
        .ow_done(ow_done), .ow_rdat(ow_rdat), .ow_presence(ow_presence),
        .busy(busy), .poll_en(poll_en)
    );

    always #5 clk = ~clk;

    int n_vec, n_err;
    int cyc;

    logic [7:0] host_q[$];
    int         rx_idx;

    int         lat = 1;
    bit         never_done = 1'b0;
    bit         presence_val = 1'b1;
    bit         hs_next;
    int         cd;
    logic [1:0] hs_cmd, cur_cmd;
    logic [7:0] hs_wdat;
    int         last_done_cyc;
    logic [1:0] req_cmd[$];
    logic [7:0] req_wdat[$];
    int         req_cyc[$];
    logic [7:0] exp_q[$];

    logic [7:0] got_q[$];
    int         got_cyc[$];

    int gi, ei, ri;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // host UART: presents queued bytes, advances on each rx_read pulse
    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_idx   = 0;
        forever begin
            @(negedge clk);
            if (!arst_n)      rx_idx = host_q.size();
            else if (rx_read) rx_idx++;
            if (rx_idx < host_q.size()) begin
                rx_valid = 1'b1;
                rx_data  = host_q[rx_idx];
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
        end
    end

    // 1-Wire master: one request at a time, done after lat cycles, random read data
    initial begin
        ow_rdy = 1'b1; ow_done = 1'b0; ow_rdat = 8'h00; ow_presence = 1'b0;
        hs_next = 1'b0; cd = 0; last_done_cyc = 0; cur_cmd = 2'd0;
        hs_cmd = 2'd0; hs_wdat = 8'h00;
        forever begin
            @(negedge clk);
            ow_done = 1'b0;
            if (!arst_n) begin
                hs_next = 1'b0; cd = 0; ow_rdy = 1'b1;
            end else begin
                if (hs_next) begin
                    hs_next = 1'b0;
                    ow_rdy  = 1'b0;
                    req_cmd.push_back(hs_cmd);
                    req_wdat.push_back(hs_wdat);
                    req_cyc.push_back(cyc);
                    cur_cmd = hs_cmd;
                    cd = never_done ? -1 : lat;
                end else if (cd < 0) begin
                    if (!never_done) begin cd = 0; ow_rdy = 1'b1; end
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        ow_done = 1'b1;
                        ow_rdy  = 1'b1;
                        last_done_cyc = cyc;
                        if (cur_cmd == 2'd2) begin
                            ow_rdat = 8'($urandom);
                            exp_q.push_back(ow_rdat);
                        end else if (cur_cmd == 2'd0) begin
                            ow_presence = presence_val;
                            exp_q.push_back({7'd0, presence_val});
                        end
                    end
                end
                if (ow_vld && ow_rdy) begin
                    hs_next = 1'b1;
                    hs_cmd  = ow_cmd;
                    hs_wdat = ow_wdat;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (arst_n && tx_write) begin
                got_q.push_back(tx_data);
                got_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [7:0] b);
        host_q.push_back(b);
    endtask

    task automatic wait_quiet(input string tag, input int max);
        int q;
        bit ok;
        q = 0;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (!busy && !tx_write && rx_idx == host_q.size() && cd == 0 && !hs_next) q++;
            else q = 0;
            if (q >= 16) ok = 1'b1;
        end
        chk({tag, "_quiet"}, 32'(ok), 32'd1);
    endtask

    task automatic cmp_bytes(input string tag);
        int n_got, n_exp;
        n_got = got_q.size() - gi;
        n_exp = exp_q.size() - ei;
        chk({tag, "_nbytes"}, n_got, n_exp);
        for (int k = 0; k < n_got && k < n_exp; k++)
            chk({tag, "_byte"}, got_q[gi+k], exp_q[ei+k]);
        gi = got_q.size();
        ei = exp_q.size();
    endtask

    task automatic wait_err_byte(input string tag, input int max);
        int k;
        k = 0;
        while (got_q.size() == gi && k < max) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(got_q.size() > gi), 32'd1);
    endtask

    initial begin
        logic [7:0] wexp[$];
        logic [7:0] b;
        int n, r, k;
        n_vec = 0; n_err = 0; gi = 0; ei = 0; ri = 0;
        tx_busy = 1'b0;

        #1 arst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_read", rx_read, 0);
        chk("rst_tx_write", tx_write, 0);
        chk("rst_ow_vld", ow_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_poll_en", poll_en, 0);
        chk("rst_tx_data", tx_data, 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        lat = 20; presence_val = 1'b1;
        send(8'h00);
        wait_quiet("t1", 400);
        chk("t1_nreq", req_cmd.size() - ri, 1);
        chk("t1_cmd", req_cmd[ri], 0);
        chk("t1_byte", got_q[gi], 8'h01);
        chk("t1_busy", busy, 0);
        cmp_bytes("t1");
        ri = req_cmd.size();

        lat = 3;
        send(8'h41); send(8'hCC); send(8'h44);
        wait_quiet("t2", 400);
        chk("t2_nreq", req_cmd.size() - ri, 2);
        chk("t2_cmd0", req_cmd[ri], 1);
        chk("t2_wdat0", req_wdat[ri], 8'hCC);
        chk("t2_cmd1", req_cmd[ri+1], 1);
        chk("t2_wdat1", req_wdat[ri+1], 8'h44);
        chk("t2_no_tx", got_q.size() - gi, 0);
        ri = req_cmd.size();

        for (int it = 0; it < 6; it++) begin
            lat = $urandom_range(1, 8);
            n = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin
                wexp.delete();
                send({2'b01, 6'(n)});
                for (int j = 0; j <= n; j++) begin
                    b = 8'($urandom);
                    wexp.push_back(b);
                    send(b);
                end
                wait_quiet("rw", 800);
                chk("rw_nreq", req_cmd.size() - ri, n + 1);
                for (int j = 0; j <= n; j++) begin
                    chk("rw_cmd", req_cmd[ri+j], 1);
                    chk("rw_wdat", req_wdat[ri+j], wexp[j]);
                end
                chk("rw_no_tx", got_q.size() - gi, 0);
            end else begin
                send({2'b10, 6'(n)});
                wait_quiet("rr", 800);
                chk("rr_nreq", req_cmd.size() - ri, n + 1);
                cmp_bytes("rr");
            end
            ri = req_cmd.size();
        end

        tx_busy = 1'b1; lat = 2;
        send(8'h88);
        repeat (300) @(negedge clk);
        chk("t3_stall_nreq", req_cmd.size() - ri, FD);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_no_tx", got_q.size() - gi, 0);
        tx_busy = 1'b0;
        wait_quiet("t3", 800);
        chk("t3_nreq", req_cmd.size() - ri, 9);
        cmp_bytes("t3");
        ri = req_cmd.size();

        lat = 1;
        send(8'h80);
        wait_quiet("lat", 200);
        chk("lat_cycles", 32'((got_cyc[got_cyc.size()-1] - last_done_cyc) <= 6), 32'd1);
        cmp_bytes("lat");
        ri = req_cmd.size();

        never_done = 1'b1;
        send(8'h80);
        wait_err_byte("tmo", TC + 100);
        chk("tmo_byte", got_q[gi], 8'hEE);
        chk("tmo_time", 32'((got_cyc[gi] - req_cyc[ri]) >= TC &&
                            (got_cyc[gi] - req_cyc[ri]) <= TC + 6), 32'd1);
        never_done = 1'b0;
        wait_quiet("tmo", 200);
        chk("tmo_busy", busy, 0);
        gi = got_q.size();
        ri = req_cmd.size();
        lat = 2;
        send(8'h81);
        wait_quiet("tmo_next", 400);
        chk("tmo_next_nreq", req_cmd.size() - ri, 2);
        cmp_bytes("tmo_next");
        ri = req_cmd.size();

        never_done = 1'b1;
        send(8'h42); send(8'h5A); send(8'hA5); send(8'h3C);
        wait_err_byte("drain", TC + 100);
        never_done = 1'b0;
        wait_quiet("drain", 400);
        chk("drain_nreq", req_cmd.size() - ri, 1);
        chk("drain_wdat", req_wdat[ri], 8'h5A);
        chk("drain_rx_empty", 32'(rx_idx == host_q.size()), 32'd1);
        chk("drain_byte", got_q[gi], 8'hEE);
        chk("drain_ntx", got_q.size() - gi, 1);
        gi = got_q.size();
        ri = req_cmd.size();
        send(8'h80);
        wait_quiet("drain_next", 400);
        cmp_bytes("drain_next");
        ri = req_cmd.size();

        lat = 3;
        send(8'h80);
        wait_quiet("poll_rd", 400);
        cmp_bytes("poll_rd");
        ri = req_cmd.size();
        send(8'hC1);
        wait_quiet("poll_mode", 100);
        chk("poll_en_on", poll_en, 1);
        k = 0;
        while (req_cmd.size() - ri < 3 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("poll_n3", 32'(req_cmd.size() - ri >= 3), 32'd1);
        chk("poll_cmd0", req_cmd[ri], 2);
        chk("poll_cmd2", req_cmd[ri+2], 2);
        chk("poll_gap0", req_cyc[ri+1] - req_cyc[ri], PC);
        chk("poll_gap1", req_cyc[ri+2] - req_cyc[ri+1], PC);
        lat = 40; presence_val = 1'($urandom_range(0, 1));
        k = 0;
        while (req_cmd.size() - ri < 4 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        chk("poll_n4", 32'(req_cmd.size() - ri >= 4), 32'd1);
        send(8'h00);
        wait_quiet("poll_rst", 400);
        chk("poll_cmd3", req_cmd[ri+3], 2);
        chk("poll_rst_after", req_cmd[ri+4], 0);
        cmp_bytes("poll");
        lat = 3;
        send(8'hC0);
        wait_quiet("poll_off", 100);
        chk("poll_en_off", poll_en, 0);
        r = req_cmd.size();
        repeat (2500) @(negedge clk);
        chk("poll_stopped", req_cmd.size() - r, 0);
        cmp_bytes("poll_off");
        ri = req_cmd.size();

        lat = 10;
        send(8'h43);
        for (int j = 0; j < 4; j++) send(8'($urandom) | 8'h01);
        k = 0;
        while (req_cmd.size() == ri && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ar_started", 32'(req_cmd.size() > ri), 32'd1);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("ar_rx_read", rx_read, 0);
        chk("ar_tx_write", tx_write, 0);
        chk("ar_ow_vld", ow_vld, 0);
        chk("ar_ow_cmd", ow_cmd, 0);
        chk("ar_ow_wdat", ow_wdat, 0);
        chk("ar_tx_data", tx_data, 0);
        chk("ar_busy", busy, 0);
        chk("ar_poll_en", poll_en, 0);
        repeat (2) @(negedge clk);
        gi = got_q.size(); ei = exp_q.size(); ri = req_cmd.size();
        arst_n = 1'b1;
        lat = 2;
        send(8'h80);
        wait_quiet("ar_rd", 400);
        chk("ar_rd_nreq", req_cmd.size() - ri, 1);
        chk("ar_rd_cmd", req_cmd[ri], 2);
        cmp_bytes("ar_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
